// File: rtl/bpu_pkg.sv
// Shared constants and types for the gshare branch predictor: default geometry,
// saturating-counter encodings and the BTB entry layout.
package bpu_pkg;

  localparam int DEF_ADDR_WIDTH  = 64;
  localparam int DEF_GHR_WIDTH   = 8;
  localparam int DEF_PHT_ENTRIES = 256;
  localparam int DEF_BTB_ENTRIES = 32;
  localparam int DEF_CNT_W       = 2;
  localparam int DEF_BTB_IDX     = $clog2(DEF_BTB_ENTRIES);
  localparam int DEF_TAG_W       = DEF_ADDR_WIDTH - DEF_BTB_IDX - 2;

  typedef enum logic [1:0] {
    CNT_STRONG_NT = 2'b00,
    CNT_WEAK_NT   = 2'b01,
    CNT_WEAK_T    = 2'b10,
    CNT_STRONG_T  = 2'b11
  } cnt_enc_e;

  typedef struct packed {
    logic                      valid;
    logic [DEF_TAG_W-1:0]      tag;
    logic [DEF_ADDR_WIDTH-1:0] target;
  } btb_entry_t;

  // Weakly-not-taken for any counter width: just below the taken threshold.
  function automatic int weak_nt_value(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/pht.sv
// Pattern history table: an array of saturating counters with one
// combinational read port and one clocked update port.
module pht
  import bpu_pkg::*;
#(
  parameter int PHT_ENTRIES = DEF_PHT_ENTRIES,
  parameter int CNT_W       = DEF_CNT_W,
  localparam int PHT_IDX    = $clog2(PHT_ENTRIES)
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [PHT_IDX-1:0] i_rd_idx,
  output logic [CNT_W-1:0]   o_rd_cnt,
  input  logic               i_upd_en,
  input  logic [PHT_IDX-1:0] i_upd_idx,
  input  logic               i_upd_taken
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(weak_nt_value(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] r_cnt [PHT_ENTRIES];

  assign o_rd_cnt = r_cnt[i_rd_idx];

  // Counters saturate at both ends rather than wrapping.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        r_cnt[i] <= CNT_INIT;
      end
    end else if (i_upd_en) begin
      if (i_upd_taken && (r_cnt[i_upd_idx] != CNT_MAX)) begin
        r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] + CNT_W'(1);
      end else if (!i_upd_taken && (r_cnt[i_upd_idx] != '0)) begin
        r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gshare_bpu.sv
// Gshare branch predictor: zero-latency fetch prediction from a PHT indexed by
// PC xor speculative history, plus a direct-mapped BTB for hit and target.
module gshare_bpu
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int GHR_WIDTH   = DEF_GHR_WIDTH,
  parameter int PHT_ENTRIES = DEF_PHT_ENTRIES,
  parameter int BTB_ENTRIES = DEF_BTB_ENTRIES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_stall_fetch,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_upd_valid,
  input  logic                  i_upd_taken,
  input  logic                  i_upd_mispredict,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic [GHR_WIDTH-1:0]  i_upd_ghr,
  output logic                  o_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pred_target,
  output logic [GHR_WIDTH-1:0]  o_ghr_snap
);

  localparam int PHT_IDX = $clog2(PHT_ENTRIES);
  localparam int BTB_IDX = $clog2(BTB_ENTRIES);
  localparam int TAG_W   = ADDR_WIDTH - BTB_IDX - 2;

  logic [GHR_WIDTH-1:0]  r_ghr;
  logic [BTB_ENTRIES-1:0] r_btbValid;
  logic [TAG_W-1:0]      r_btbTag    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0] r_btbTarget [BTB_ENTRIES];

  logic [BTB_IDX-1:0] w_fetchBtbIdx;
  logic [TAG_W-1:0]   w_fetchTag;
  logic [PHT_IDX-1:0] w_fetchPhtIdx;
  logic [CNT_W-1:0]   w_fetchCnt;
  logic               w_btbHit;
  logic [BTB_IDX-1:0] w_updBtbIdx;
  logic [PHT_IDX-1:0] w_updPhtIdx;
  logic               w_btbWrite;
  logic               w_unused;

  assign w_fetchBtbIdx = i_pc[BTB_IDX+1:2];
  assign w_fetchTag    = i_pc[ADDR_WIDTH-1:BTB_IDX+2];
  assign w_fetchPhtIdx = i_pc[PHT_IDX+1:2] ^ PHT_IDX'(r_ghr);
  assign w_updBtbIdx   = i_upd_pc[BTB_IDX+1:2];
  assign w_updPhtIdx   = i_upd_pc[PHT_IDX+1:2] ^ PHT_IDX'(i_upd_ghr);
  assign w_btbWrite    = i_upd_valid && i_upd_taken;
  assign w_unused      = ^{i_pc[1:0], i_upd_pc[1:0]};

  assign w_btbHit      = r_btbValid[w_fetchBtbIdx] && (r_btbTag[w_fetchBtbIdx] == w_fetchTag);
  assign o_pred_taken  = w_btbHit && w_fetchCnt[CNT_W-1];
  assign o_pred_target = w_btbHit ? r_btbTarget[w_fetchBtbIdx] : i_pc + ADDR_WIDTH'(4);
  assign o_ghr_snap    = r_ghr;

  pht #(
    .PHT_ENTRIES(PHT_ENTRIES),
    .CNT_W      (CNT_W)
  ) u_pht (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_rd_idx   (w_fetchPhtIdx),
    .o_rd_cnt   (w_fetchCnt),
    .i_upd_en   (i_upd_valid),
    .i_upd_idx  (w_updPhtIdx),
    .i_upd_taken(i_upd_taken)
  );

  // Misprediction recovery rebuilds history from the branch's own snapshot and wins over speculation.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_ghr <= '0;
    end else if (i_upd_valid && i_upd_mispredict) begin
      r_ghr <= {i_upd_ghr[GHR_WIDTH-2:0], i_upd_taken};
    end else if (w_btbHit && !i_stall_fetch) begin
      r_ghr <= {r_ghr[GHR_WIDTH-2:0], o_pred_taken};
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_btbValid <= '0;
    end else if (w_btbWrite) begin
      r_btbValid[w_updBtbIdx] <= 1'b1;
    end
  end

  // Tag and target are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (w_btbWrite) begin
      r_btbTag[w_updBtbIdx]    <= i_upd_pc[ADDR_WIDTH-1:BTB_IDX+2];
      r_btbTarget[w_updBtbIdx] <= i_upd_target;
    end
  end

endmodule

// File: tb/tb_gshare_bpu.sv
// Directed self-checking bench for gshare_bpu with default geometry
// (PHT index = pc[9:2], BTB index = pc[6:2]).
module tb_gshare_bpu;

  logic        clk;
  logic        arst_n;
  logic        stall;
  logic [63:0] pc;
  logic        updValid;
  logic        updTaken;
  logic        updMispredict;
  logic [63:0] updPc;
  logic [63:0] updTarget;
  logic [7:0]  updGhr;
  logic        predTaken;
  logic [63:0] predTarget;
  logic [7:0]  ghrSnap;

  int errors;
  int checks;

  gshare_bpu dut (
    .i_clk           (clk),
    .i_arst_n        (arst_n),
    .i_stall_fetch   (stall),
    .i_pc            (pc),
    .i_upd_valid     (updValid),
    .i_upd_taken     (updTaken),
    .i_upd_mispredict(updMispredict),
    .i_upd_pc        (updPc),
    .i_upd_target    (updTarget),
    .i_upd_ghr       (updGhr),
    .o_pred_taken    (predTaken),
    .o_pred_target   (predTarget),
    .o_ghr_snap      (ghrSnap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic s, input logic [63:0] p, input logic uv,
                               input logic ut, input logic um, input logic [63:0] upc,
                               input logic [63:0] utgt, input logic [7:0] ughr);
    stall         = s;
    pc            = p;
    updValid      = uv;
    updTaken      = ut;
    updMispredict = um;
    updPc         = upc;
    updTarget     = utgt;
    updGhr        = ughr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    arst_n = 1'b0;
    applyStimulus(0, 64'h100, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("inrst_taken", predTaken, 1'b0);
    checkOutput("inrst_target", predTarget, 64'h104);
    checkOutput("inrst_ghr", ghrSnap, 8'h00);
    #10 arst_n = 1'b1;
    step();

    #2;
    checkOutput("post_rst_taken", predTaken, 1'b0);
    checkOutput("post_rst_target", predTarget, 64'h104);
    checkOutput("post_rst_ghr", ghrSnap, 8'h00);

    // Training under stall so the speculative history stays at zero.
    applyStimulus(1, 64'h100, 1, 1, 0, 64'h100, 64'h400, 8'h00);
    step();
    step();

    applyStimulus(0, 64'h100, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("train_taken", predTaken, 1'b1);
    checkOutput("train_target", predTarget, 64'h400);
    step();
    applyStimulus(1, 64'h100, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("train_ghr_shift", ghrSnap, 8'h01);

    // Counter 11 saturates through three taken updates, then a mispredicted not-taken drops it to 10.
    applyStimulus(1, 64'h100, 1, 1, 0, 64'h100, 64'h400, 8'h00);
    repeat (3) step();
    applyStimulus(1, 64'h100, 1, 0, 1, 64'h100, 64'h400, 8'h00);
    step();

    applyStimulus(0, 64'h100, 1, 0, 1, 64'h100, 64'h400, 8'h00);
    #2;
    checkOutput("sat_ghr_recovered", ghrSnap, 8'h00);
    checkOutput("sat_taken", predTaken, 1'b1);
    checkOutput("sat_target", predTarget, 64'h400);
    step();

    // Counter now 01; hit with no stall coincides with a 0xA5 recovery.
    applyStimulus(0, 64'h100, 1, 0, 1, 64'h100, 64'h0, 8'hA5);
    #2;
    checkOutput("prio_ghr_before", ghrSnap, 8'h00);
    checkOutput("sat_nowrap_taken", predTaken, 1'b0);
    checkOutput("sat_nowrap_target", predTarget, 64'h400);
    step();

    applyStimulus(1, 64'h100, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("prio_ghr", ghrSnap, 8'h4A);
    checkOutput("stall_hit_target", predTarget, 64'h400);
    checkOutput("stall_hit_taken", predTaken, 1'b0);
    step();

    // Alias miss on 0x180 while a taken update replaces the shared BTB entry.
    applyStimulus(0, 64'h180, 1, 1, 0, 64'h180, 64'h800, 8'h00);
    #2;
    checkOutput("stall_ghr_held", ghrSnap, 8'h4A);
    checkOutput("alias_taken", predTaken, 1'b0);
    checkOutput("alias_target_old", predTarget, 64'h184);
    step();

    applyStimulus(1, 64'h180, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("alias_miss_ghr_held", ghrSnap, 8'h4A);
    checkOutput("btb_new_target", predTarget, 64'h800);
    checkOutput("btb_new_taken", predTaken, 1'b0);
    applyStimulus(1, 64'h100, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("btb_evicted_target", predTarget, 64'h104);

    applyStimulus(1, 64'h100, 1, 1, 0, 64'h100, 64'h400, 8'h00);
    step();
    step();
    applyStimulus(1, 64'h100, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("retrain_target", predTarget, 64'h400);
    arst_n = 1'b0;
    #1;
    checkOutput("midrst_taken", predTaken, 1'b0);
    checkOutput("midrst_target", predTarget, 64'h104);
    checkOutput("midrst_ghr", ghrSnap, 8'h00);
    #2 arst_n = 1'b1;
    step();

    applyStimulus(0, 64'h100, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("after_midrst_taken", predTaken, 1'b0);
    checkOutput("after_midrst_target", predTarget, 64'h104);
    checkOutput("after_midrst_ghr", ghrSnap, 8'h00);

    // A freshly reset counter (01) goes 10 then back to 01, so fetch predicts not-taken.
    applyStimulus(1, 64'h100, 1, 1, 0, 64'h100, 64'h400, 8'h00);
    step();
    applyStimulus(1, 64'h100, 1, 0, 0, 64'h100, 64'h400, 8'h00);
    step();
    applyStimulus(0, 64'h100, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    #2;
    checkOutput("pht_reset_taken", predTaken, 1'b0);
    checkOutput("pht_reset_target", predTarget, 64'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
